// File: rtl/kf_arb_pkg.sv
// Shared types and default sizing for the Kalman-filter engine request arbiter.
package kf_arb_pkg;

  localparam int unsigned KF_NUM_REQ     = 4;
  localparam int unsigned KF_ARB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer followed by a rising-edge detector for one async request line.
module sync_rise (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic rise_out
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= async_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign rise_out = r_s2 & ~r_prev;

endmodule

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter sharing one Kalman update engine among asynchronous requesters,
// with done/timeout release and sticky per-line overrun flags.
module sync_req_arbiter
  import kf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = KF_NUM_REQ,
  parameter int unsigned TIMEOUT = KF_ARB_TIMEOUT,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] async_req,
  input  logic               eng_done,
  output logic               eng_start,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] pending,
  output logic               timeout,
  output logic [NUM_REQ-1:0] overrun
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);

  // First set bit at or above ptr, wrapping past NUM_REQ-1.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] sel;
    logic            found;
    idx   = ptr;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = (idx == ID_LAST) ? '0 : idx + 1'b1;
    end
    return sel;
  endfunction

  arb_state_t         r_state;
  arb_state_t         w_state_d;
  logic [NUM_REQ-1:0] r_grant;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] r_overrun;

  logic [NUM_REQ-1:0] w_rise;
  logic               w_any;
  logic [ID_W-1:0]    w_pick;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [NUM_REQ-1:0] w_grant_clear;
  logic               w_cnt_last;
  logic               w_release;
  logic [ID_W-1:0]    w_rr_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sync
    sync_rise u_sync_rise (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (async_req[gi]),
      .rise_out (w_rise[gi])
    );
  end

  assign w_any         = |r_pending;
  assign w_pick        = rr_pick(r_pending, r_rr_ptr);
  assign w_pick_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_grant_clear = (r_state == IDLE && w_any) ? w_pick_oh : '0;
  assign w_cnt_last    = (r_cnt == CNT_LAST);
  // Done has priority over a simultaneous timeout.
  assign w_release     = (r_state == BUSY) && (eng_done || w_cnt_last);
  assign w_rr_next     = (r_grant_id == ID_LAST) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_d = START;
      START:   w_state_d = BUSY;
      BUSY:    if (w_release) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_overrun  <= '0;
    end else begin
      r_state   <= w_state_d;
      // A rise coinciding with its own grant clear is kept as a fresh request.
      r_pending <= (r_pending & ~w_grant_clear) | w_rise;
      r_overrun <= r_overrun | (w_rise & r_pending & ~w_grant_clear);
      if (r_state == IDLE && w_any) begin
        r_grant    <= w_pick_oh;
        r_grant_id <= w_pick;
      end
      if (w_release) begin
        r_grant  <= '0;
        r_rr_ptr <= w_rr_next;
        r_cnt    <= '0;
      end else if (r_state == BUSY && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign eng_start = (r_state == START);
  assign busy      = (r_state != IDLE);
  assign grant     = r_grant;
  assign grant_id  = r_grant_id;
  assign pending   = r_pending;
  assign overrun   = r_overrun;
  assign timeout   = (r_state == BUSY) && !eng_done && w_cnt_last;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level
// behavioural model of the arbiter (owner / age-since-grant / round-robin pointer).
module tb_sync_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] async_req = '0;
  logic       eng_done = 1'b0;
  logic       eng_start;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic       timeout;
  logic [3:0] overrun;

  sync_req_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .async_req (async_req),
    .eng_done  (eng_done),
    .eng_start (eng_start),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy),
    .pending   (pending),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: samples of async_req at the last three edges, owner (-1 = none),
  // age (0 = start cycle, k = k-th busy cycle), round-robin pointer.
  logic [3:0] p1, p2, p3;
  int         m_owner, m_age, m_ptr, m_gid;
  logic [3:0] m_pend, m_ovr;
  int         olog[$];
  int         tcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    p1 = '0; p2 = '0; p3 = '0;
    m_owner = -1; m_age = 0; m_ptr = 0; m_gid = 0;
    m_pend = '0; m_ovr = '0;
  endtask

  task automatic m_edge();
    logic [3:0] r, clr;
    int idx;
    r   = p2 & ~p3;
    p3  = p2; p2 = p1; p1 = async_req;
    clr = '0;
    if (m_owner < 0) begin
      if (m_pend != 0) begin
        for (int k = N - 1; k >= 0; k--) begin
          idx = (m_ptr + k) % N;
          if (m_pend[idx]) m_owner = idx;
        end
        clr[m_owner] = 1'b1;
        m_gid = m_owner;
        m_age = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (eng_done || m_age == TO) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_age++;
    end
    m_ovr  = m_ovr | (r & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | r;
  endtask

  task automatic check_all();
    logic       e_busy;
    logic [3:0] e_grant;
    e_busy  = (m_owner >= 0);
    e_grant = e_busy ? (4'b0001 << m_owner) : 4'b0000;
    chk("busy", busy, e_busy);
    chk("eng_start", eng_start, e_busy && m_age == 0);
    chk("grant", grant, e_grant);
    chk("pending", pending, m_pend);
    chk("overrun", overrun, m_ovr);
    chk("timeout", timeout, e_busy && m_age == TO && !eng_done);
    if (e_busy) chk("grant_id", grant_id, m_gid);
  endtask

  // Entered at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    #2;
    check_all();
    if (eng_start === 1'b1) olog.push_back(int'(grant_id));
    if (timeout === 1'b1) tcount++;
    @(posedge clk);
    if (n_rst) m_edge();
    #1;
  endtask

  // Engine answers done when the model's age equals d1 or d2 (-1 disables).
  task automatic run(input int n, input int d1, input int d2);
    repeat (n) begin
      eng_done = (m_owner >= 0) && (m_age == d1 || m_age == d2);
      step();
    end
    eng_done = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    async_req = '0;
    eng_done = 1'b0;
    m_reset();
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", eng_start, 1'b0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_gid", grant_id, 2'd0);
    chk("rst_pend", pending, 4'b0000);
    chk("rst_to", timeout, 1'b0);
    chk("rst_ovr", overrun, 4'b0000);
    step();
    step();
    n_rst = 1'b1;
    olog.delete();
    tcount = 0;
  endtask

  initial begin
    m_reset();
    tcount = 0;

    // Held level on line 2, engine never answers: one grant, one timeout.
    do_reset();
    async_req[2] = 1'b1;
    run(30, -1, -1);
    chk("t1_pend", pending, 4'b0000);
    chk("t1_ngrant", olog.size(), 1);
    if (olog.size() > 0) chk("t1_id", olog[0], 2);
    chk("t1_to", tcount, 1);

    // All four rise together, done two cycles after each start.
    do_reset();
    async_req = 4'hF;
    run(30, 2, -1);
    chk("t2_ngrant", olog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_order%0d", i), (i < olog.size()) ? olog[i] : -1, i);
    chk("t2_ovr", overrun, 4'b0000);

    // Line 1 re-requests during its own grant, line 3 also waiting.
    do_reset();
    async_req = 4'b0010;
    run(6, 8, -1);
    async_req = 4'b0000;
    run(2, 8, -1);
    async_req = 4'b1010;
    run(40, 8, -1);
    chk("t3_ngrant", olog.size(), 3);
    if (olog.size() == 3) begin
      chk("t3_o0", olog[0], 1);
      chk("t3_o1", olog[1], 3);
      chk("t3_o2", olog[2], 1);
    end
    chk("t3_ovr", overrun, 4'b0000);

    // Two edges on line 0 while it is pending and line 3 holds the engine.
    do_reset();
    async_req = 4'b1000;
    run(6, -1, -1);
    async_req = 4'b1001;
    run(4, -1, -1);
    async_req = 4'b1000;
    run(3, -1, -1);
    async_req = 4'b1001;
    run(4, -1, -1);
    async_req = 4'b0000;
    run(30, 3, -1);
    chk("t4_ovr", overrun, 4'b0001);
    chk("t4_ngrant", olog.size(), 2);
    if (olog.size() == 2) begin
      chk("t4_o0", olog[0], 3);
      chk("t4_o1", olog[1], 0);
    end

    // Done on the last counter value beats timeout; done in START is ignored.
    do_reset();
    async_req = 4'b0001;
    run(30, 16, -1);
    chk("t5_to", tcount, 0);
    async_req = 4'b0100;
    run(14, 0, 5);
    chk("t5_to2", tcount, 0);
    chk("t5_ngrant", olog.size(), 2);

    // Asynchronous reset in BUSY with other requests pending.
    do_reset();
    async_req = 4'b0001;
    run(5, -1, -1);
    async_req = 4'b1011;
    run(4, -1, -1);
    chk("t6_pend", pending, 4'b1010);
    chk("t6_busy", busy, 1'b1);
    do_reset();
    run(10, -1, -1);
    chk("t6_nogrant", olog.size(), 0);

    // Random traffic, random engine completion (including during START).
    do_reset();
    repeat (3000) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) async_req[b] = ~async_req[b];
      eng_done = ($urandom_range(0, 5) == 0);
      step();
    end
    eng_done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_req_arbiter.md
Name: sync_req_arbiter

Overview:
- Round-robin arbiter that shares one Kalman filter update engine among NUM_REQ requesters whose request lines are asynchronous to clk (sensor/ADC data-ready strobes).
- Each request line is synchronized and rising-edge detected, then latched as a pending request.
- Pending requests are granted one at a time: a start pulse goes to the engine, and the arbiter waits for done or a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 255, max clk cycles in BUSY before the grant is forcibly released (>=2).
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- async_req  input  NUM_REQ  asynchronous request lines; a rising edge is one request.
- eng_done  input  1  engine completion pulse, synchronous to clk.
- eng_start  output  1  one-cycle start pulse to the engine.
- grant  output  NUM_REQ  one-hot grant; held from START through end of BUSY.
- grant_id  output  ID_W  binary index of the granted requester; valid while busy=1.
- busy  output  1  high in START and BUSY.
- pending  output  NUM_REQ  latched, not-yet-granted requests.
- timeout  output  1  one-cycle pulse when a grant is released by timeout.
- overrun  output  NUM_REQ  sticky; bit i sets when an edge arrives while pending[i] is already 1.

Behaviour:
- Reset is asynchronous, active-low, clk is the only clock. On reset, all flops clear:
  - eng_start=0, grant=0, grant_id=0, busy=0, pending=0, timeout=0, overrun=0.
  - FSM=IDLE, rr_ptr=0, timeout counter=0.
- Reset mid-operation abandons the grant with no done or timeout pulse.
- Synchronization, per line:
  - Path is s1 <= async_req[i], s2 <= s1, prev <= s2.
  - rise[i] = s2 & ~prev.
  - A level sampled high at edge k gives rise at k+1 and pending[i]=1 after edge k+2.
  - A line held high produces only one request.
- Pending update, each cycle: pending_next = (pending & ~grant_clear) | rise.
  - If rise[i] and grant_clear[i] occur in the same cycle, the bit stays 1; the new request is queued.
  - If rise[i]=1 while pending[i]=1 and there is no clear, the request is coalesced and overrun[i] sets.
  - overrun clears only on reset.
- FSM states:
  - IDLE: if pending != 0, select the first set bit searching from rr_ptr upward with wrap. Register grant and grant_id, clear that pending bit (grant_clear), assert eng_start, go to START.
  - START: lasts one cycle, eng_start=1. Always go to BUSY. eng_done is ignored in START.
  - BUSY: the counter increments each cycle.
    - On eng_done=1: go to IDLE and clear grant.
    - Else if counter == TIMEOUT-1: pulse timeout, go to IDLE, clear grant.
    - If eng_done and the timeout arrive in the same cycle, done wins and there is no timeout pulse.
    - On leaving BUSY, rr_ptr = grant_id+1, wrapping to 0 past NUM_REQ-1, and the counter clears.
- Latency and throughput:
  - Arbitration decision to eng_start is registered, one cycle after pending is visible in IDLE.
  - Minimum time between consecutive grants is 3 cycles: START, BUSY with immediate done, IDLE.
  - Grant changes only through IDLE; busy=0 for exactly one cycle between grants.
- Width rules: the counter is $clog2(TIMEOUT+1) bits and saturates safely. rr_ptr is ID_W bits, and wrap is explicit for non-power-of-2 NUM_REQ.

Decomposition:
- Package kf_arb_pkg:
  - state enum arb_state_t {IDLE, START, BUSY}, 2 bits.
  - Default constants KF_NUM_REQ=4 and KF_ARB_TIMEOUT=255.
- Sub-module sync_rise (clk, n_rst, async_in, rise_out):
  - Two-flop synchronizer plus edge-detect flop.
  - Instantiated NUM_REQ times with generate.
- Round-robin selection stays inline as a combinational function.

Test Plan (NUM_REQ=4, TIMEOUT=16):
- async_req[2] rises between edges and stays high, eng_done never asserted -> pending[2]=1 two edges after the first sampling edge. eng_start pulses the next cycle with grant=4'b0100, grant_id=2. timeout pulses at BUSY cycle 16. pending stays 0 because the held level gives no second request.
- async_req=4'b1111 rise together, eng_done returned 2 cycles after each eng_start -> grant order 0,1,2,3. busy low for exactly one cycle between grants. No overrun.
- Grant 1 active; async_req[1] pulses again -> pending[1]=1 while grant[1]=1. After done, requester 1 is re-granted only after any other pending requesters, per round robin.
- async_req[0] makes two separate rising edges while pending[0]=1 and the engine is busy with requester 3 -> overrun[0]=1 (sticky), and requester 0 gets only one grant.
- eng_done asserted on the same cycle the counter reaches 15 -> no timeout pulse, normal release. Separately, eng_done during START -> ignored, and the arbiter stays in BUSY.
- n_rst asserted in BUSY with pending=4'b1010 -> all outputs 0 immediately, asynchronously. After release, no grant occurs until new edges arrive.
